// File: rtl/ccu_slice_clk_ctrl_if.sv
// Config and per-slice clkreq/clkack bundle for the CCU slice clock controller.
// master drives config and requests; slave returns ack, enable, busy and error.
interface ccu_slice_clk_ctrl_if #(
    parameter int NUM_SLICES = 4,
    parameter int DLY_W      = 8
);
    localparam int SW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    logic                  cfg_wr_en;
    logic [SW-1:0]         cfg_slice;
    logic [DLY_W-1:0]      cfg_req_dly;
    logic [DLY_W-1:0]      cfg_ack_dly;
    logic [NUM_SLICES-1:0] cfg_force_on;
    logic [NUM_SLICES-1:0] slice_clkreq;
    logic [NUM_SLICES-1:0] slice_clkack;
    logic [NUM_SLICES-1:0] slice_clken;
    logic [NUM_SLICES-1:0] slice_busy;
    logic [NUM_SLICES-1:0] proto_err;

    modport master (
        output cfg_wr_en, cfg_slice, cfg_req_dly, cfg_ack_dly,
        output cfg_force_on, slice_clkreq,
        input  slice_clkack, slice_clken, slice_busy, proto_err
    );

    modport slave (
        input  cfg_wr_en, cfg_slice, cfg_req_dly, cfg_ack_dly,
        input  cfg_force_on, slice_clkreq,
        output slice_clkack, slice_clken, slice_busy, proto_err
    );
endinterface

// File: rtl/ccu_slice_clk_ctrl.sv
// Multi-slice four-phase clkreq/clkack controller with programmable
// assert/deassert delays, force-on clock enable and sticky protocol error.
module ccu_slice_clk_ctrl #(
    parameter int NUM_SLICES  = 4,
    parameter int DLY_W       = 8,
    parameter int DEF_REQ_DLY = 4,
    parameter int DEF_ACK_DLY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ccu_slice_clk_ctrl_if.slave   bus
);
    localparam int SW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {
        S_OFF,
        S_UP,
        S_ON,
        S_DN
    } state_t;

    logic [NUM_SLICES-1:0] w_ack;
    logic [NUM_SLICES-1:0] w_en;
    logic [NUM_SLICES-1:0] w_busy;
    logic [NUM_SLICES-1:0] w_err;

    for (genvar g = 0; g < NUM_SLICES; g++) begin : g_slice
        state_t           r_state;
        state_t           w_nxt;
        logic [DLY_W-1:0] r_cnt;
        logic [DLY_W-1:0] w_cnt_nxt;
        logic [DLY_W-1:0] r_req_dly;
        logic [DLY_W-1:0] r_ack_dly;
        logic             r_ack;
        logic             r_en;
        logic             r_busy;
        logic             r_err;
        logic             w_err_set;
        logic             w_wr;
        logic             w_req;
        logic             w_on;

        // Unmatched indices (non power-of-two counts) hit no slice.
        assign w_wr  = bus.cfg_wr_en && (bus.cfg_slice == SW'(g));
        assign w_req = bus.slice_clkreq[g];
        assign w_on  = (r_state == S_ON) || (r_state == S_DN);

        always_comb begin
            w_nxt     = r_state;
            w_cnt_nxt = r_cnt;
            w_err_set = 1'b0;
            unique case (r_state)
                S_OFF: begin
                    if (w_req) begin
                        w_nxt     = S_UP;
                        w_cnt_nxt = r_req_dly;
                    end
                end
                S_UP: begin
                    w_err_set = !w_req;
                    if (r_cnt == '0) w_nxt = S_ON;
                    else w_cnt_nxt = r_cnt - 1'b1;
                end
                S_ON: begin
                    if (!w_req) begin
                        w_nxt     = S_DN;
                        w_cnt_nxt = r_ack_dly;
                    end
                end
                S_DN: begin
                    if (r_cnt == '0) w_nxt = S_OFF;
                    else w_cnt_nxt = r_cnt - 1'b1;
                end
                default: w_nxt = S_OFF;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= S_OFF;
                r_cnt     <= '0;
                r_req_dly <= DLY_W'(DEF_REQ_DLY);
                r_ack_dly <= DLY_W'(DEF_ACK_DLY);
                r_ack     <= 1'b0;
                r_en      <= 1'b0;
                r_busy    <= 1'b0;
                r_err     <= 1'b0;
            end else begin
                r_state <= w_nxt;
                r_cnt   <= w_cnt_nxt;
                if (w_wr) begin
                    r_req_dly <= bus.cfg_req_dly;
                    r_ack_dly <= bus.cfg_ack_dly;
                end
                r_ack  <= w_on;
                r_en   <= w_on | bus.cfg_force_on[g];
                r_busy <= (r_state == S_UP) || (r_state == S_DN);
                r_err  <= r_err | w_err_set;
            end
        end

        assign w_ack[g]  = r_ack;
        assign w_en[g]   = r_en;
        assign w_busy[g] = r_busy;
        assign w_err[g]  = r_err;
    end

    assign bus.slice_clkack = w_ack;
    assign bus.slice_clken  = w_en;
    assign bus.slice_busy   = w_busy;
    assign bus.proto_err    = w_err;
endmodule

// File: tb/tb_ccu_slice_clk_ctrl.sv
// Directed bench for ccu_slice_clk_ctrl: latencies, reconfig, force-on,
// protocol error, reset mid-handshake and out-of-range config writes.
module tb_ccu_slice_clk_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tot = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ccu_slice_clk_ctrl_if #(.NUM_SLICES(4), .DLY_W(8)) ifc ();
    ccu_slice_clk_ctrl_if #(.NUM_SLICES(3), .DLY_W(8)) ifc3 ();

    ccu_slice_clk_ctrl #(
        .NUM_SLICES(4), .DLY_W(8), .DEF_REQ_DLY(4), .DEF_ACK_DLY(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(ifc.slave)
    );

    ccu_slice_clk_ctrl #(
        .NUM_SLICES(3), .DLY_W(8), .DEF_REQ_DLY(4), .DEF_ACK_DLY(4)
    ) dut3 (
        .clk(clk), .rst(rst), .bus(ifc3.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ack[s]==lvl; lat excludes the sampling edge.
    task automatic wait_ack(
        input  int s, input bit lvl, input int max,
        input  bit wr, input int wr_at, input int ws,
        input  int rd, input int ad,
        output int lat
    );
        lat = -1;
        for (int n = 1; n <= max; n++) begin
            if (wr && n == wr_at) begin
                ifc.cfg_wr_en   = 1'b1;
                ifc.cfg_slice   = 2'(ws);
                ifc.cfg_req_dly = 8'(rd);
                ifc.cfg_ack_dly = 8'(ad);
            end
            step();
            ifc.cfg_wr_en = 1'b0;
            if (ifc.slice_clkack[s] == lvl) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    task automatic cfg_wr(input int ws, input int rd, input int ad);
        ifc.cfg_wr_en   = 1'b1;
        ifc.cfg_slice   = 2'(ws);
        ifc.cfg_req_dly = 8'(rd);
        ifc.cfg_ack_dly = 8'(ad);
        step();
        ifc.cfg_wr_en = 1'b0;
    endtask

    task automatic handshake(input int s, input int up, input int dn);
        int lat;
        ifc.slice_clkreq[s] = 1'b1;
        wait_ack(s, 1'b1, 40, 1'b0, 0, 0, 0, 0, lat);
        check($sformatf("up_lat_s%0d", s), lat, up);
        ifc.slice_clkreq[s] = 1'b0;
        wait_ack(s, 1'b0, 40, 1'b0, 0, 0, 0, 0, lat);
        check($sformatf("dn_lat_s%0d", s), lat, dn);
    endtask

    initial begin
        int lat;
        ifc.cfg_wr_en     = 1'b0;
        ifc.cfg_slice     = '0;
        ifc.cfg_req_dly   = '0;
        ifc.cfg_ack_dly   = '0;
        ifc.cfg_force_on  = '0;
        ifc.slice_clkreq  = '0;
        ifc3.cfg_wr_en    = 1'b0;
        ifc3.cfg_slice    = '0;
        ifc3.cfg_req_dly  = '0;
        ifc3.cfg_ack_dly  = '0;
        ifc3.cfg_force_on = '0;
        ifc3.slice_clkreq = '0;
        step();
        step();
        check("rst_ack", int'(ifc.slice_clkack), 0);
        check("rst_en", int'(ifc.slice_clken), 0);
        check("rst_busy", int'(ifc.slice_busy), 0);
        check("rst_err", int'(ifc.proto_err), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Slice 0 default timing with busy window
        ifc.slice_clkreq[0] = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            step();
            check($sformatf("busy0_n%0d", n),
                  int'(ifc.slice_busy[0]), (n >= 2 && n <= 6) ? 1 : 0);
            check($sformatf("ack0_n%0d", n),
                  int'(ifc.slice_clkack[0]), (n == 7) ? 1 : 0);
        end
        check("en0_up", int'(ifc.slice_clken[0]), 1);
        for (int i = 0; i < 13; i++) step();
        ifc.slice_clkreq[0] = 1'b0;
        wait_ack(0, 1'b0, 40, 1'b0, 0, 0, 0, 0, lat);
        check("dn_lat_s0_first", lat, 6);
        check("en0_dn", int'(ifc.slice_clken[0]), 0);

        // Slice 2 reprogrammed; others unchanged
        cfg_wr(2, 0, 10);
        handshake(2, 2, 12);
        handshake(0, 6, 6);
        handshake(1, 6, 6);
        handshake(3, 6, 6);

        // Slice 1 rewritten mid UP_WAIT (cnt==3)
        ifc.slice_clkreq[1] = 1'b1;
        wait_ack(1, 1'b1, 40, 1'b1, 3, 1, 20, 4, lat);
        check("up_lat_s1_oldcnt", lat, 6);
        ifc.slice_clkreq[1] = 1'b0;
        wait_ack(1, 1'b0, 40, 1'b0, 0, 0, 0, 0, lat);
        check("dn_lat_s1_oldcnt", lat, 6);
        handshake(1, 22, 6);

        // Slice 3 clkreq drop during UP_WAIT
        ifc.slice_clkreq[3] = 1'b1;
        step();
        step();
        ifc.slice_clkreq[3] = 1'b0;
        step();
        check("err3_set", int'(ifc.proto_err), 8);
        wait_ack(3, 1'b1, 40, 1'b0, 0, 0, 0, 0, lat);
        check("err3_up_lat", lat, 3);
        wait_ack(3, 1'b0, 40, 1'b0, 0, 0, 0, 0, lat);
        check("err3_dn_lat", lat, 5);
        step();
        check("err3_sticky", int'(ifc.proto_err), 8);
        check("err3_busy", int'(ifc.slice_busy[3]), 0);

        // Force-on for slice 1
        ifc.cfg_force_on[1] = 1'b1;
        step();
        check("force_en", int'(ifc.slice_clken), 2);
        check("force_ack", int'(ifc.slice_clkack), 0);
        step();
        check("force_busy", int'(ifc.slice_busy), 0);
        ifc.cfg_force_on[1] = 1'b0;
        step();
        check("force_off_en", int'(ifc.slice_clken), 0);

        // Reset during DN_WAIT with clkreq high
        ifc.slice_clkreq = 4'hf;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (ifc.slice_clkack == 4'hf) begin
                lat = n - 1;
                break;
            end
        end
        check("all_up_lat", lat, 22);
        ifc.slice_clkreq = 4'h0;
        step();
        step();
        check("all_dn_busy", int'(ifc.slice_busy), 15);
        ifc.slice_clkreq = 4'hf;
        rst = 1'b1;
        step();
        check("mid_rst_ack", int'(ifc.slice_clkack), 0);
        check("mid_rst_en", int'(ifc.slice_clken), 0);
        check("mid_rst_busy", int'(ifc.slice_busy), 0);
        check("mid_rst_err", int'(ifc.proto_err), 0);
        rst = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (ifc.slice_clkack != 4'h0) begin
                lat = n - 1;
                break;
            end
        end
        check("post_rst_lat", lat, 6);
        check("post_rst_all", int'(ifc.slice_clkack), 15);

        // Out-of-range write on the 3-slice instance
        ifc3.cfg_wr_en   = 1'b1;
        ifc3.cfg_slice   = 2'd3;
        ifc3.cfg_req_dly = 8'd0;
        ifc3.cfg_ack_dly = 8'd0;
        step();
        ifc3.cfg_wr_en    = 1'b0;
        ifc3.slice_clkreq = 3'b111;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (ifc3.slice_clkack != 3'b000) begin
                lat = n - 1;
                break;
            end
        end
        check("oor_lat", lat, 6);
        check("oor_all", int'(ifc3.slice_clkack), 7);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/ccu_slice_clk_ctrl.md
# ccu_slice_clk_ctrl

Parametrised multi-slice clock request/acknowledge controller for the CCU clocking path. Each of NUM_SLICES slices runs an independent four-phase clkreq/clkack handshake with runtime-programmable assert and deassert delays, and drives a per-slice clock enable. It replaces single-channel fixed-delay CCU handshake logic, adding per-slice delay registers, a force-on override and protocol-violation flagging. It sits between agent clkreq sources and the clock-gating cells in the sideband clock domain.

## Interface
- NUM_SLICES, 4, number of independent slices (1..16)
- DLY_W, 8, width of delay counters and config fields
- DEF_REQ_DLY, 4, reset value of every slice's assert delay
- DEF_ACK_DLY, 4, reset value of every slice's deassert delay

- clk  in  1  single block clock
- rst  in  1  synchronous, active-high reset
- cfg_wr_en  in  1  config write strobe, one cycle
- cfg_slice  in  $clog2(NUM_SLICES) (min 1)  target slice of write
- cfg_req_dly  in  DLY_W  assert delay written on cfg_wr_en
- cfg_ack_dly  in  DLY_W  deassert delay written on cfg_wr_en
- cfg_force_on  in  NUM_SLICES  per-slice clock enable override (level)
- slice_clkreq  in  NUM_SLICES  clock request per slice
- slice_clkack  out  NUM_SLICES  clock acknowledge per slice
- slice_clken  out  NUM_SLICES  clock gate enable per slice
- slice_busy  out  NUM_SLICES  slice in UP_WAIT or DN_WAIT
- proto_err  out  NUM_SLICES  sticky: clkreq dropped before clkack

## Operation
- Per-slice FSM, states OFF, UP_WAIT, ON, DN_WAIT; DLY_W-bit down-counter cnt; registered req_dly/ack_dly.
- OFF: clkreq=1 -> UP_WAIT, cnt<=req_dly. Level-sensitive; no edge detect.
- UP_WAIT: cnt==0 -> ON, else cnt<=cnt-1. clkreq=0 here sets proto_err, does not abort; on reaching ON, if clkreq is 0 then the next cycle goes to DN_WAIT as normal.
- ON: clkreq=0 -> DN_WAIT, cnt<=ack_dly.
- DN_WAIT: cnt==0 -> OFF, else cnt<=cnt-1. clkreq re-asserted here is ignored until OFF, then restarts UP_WAIT; no error.
- Outputs are registered from state: clkack=1 and clken=1 in ON and DN_WAIT; both 0 in OFF and UP_WAIT; busy=1 in UP_WAIT/DN_WAIT.
- clken additionally ORed with cfg_force_on (registered, one-cycle latency). Force-on never affects clkack or FSM.
- Config write: cfg_wr_en with cfg_slice < NUM_SLICES updates that slice's req_dly and ack_dly on the next edge. Out-of-range cfg_slice is ignored. A count in progress keeps its loaded value; new delays apply at next load.
- Write and load in the same cycle: the load uses the old value.
- proto_err clears only on rst.

## Timing
- Reset: all outputs 0, all FSMs OFF, cnt=0, delay registers = DEF_REQ_DLY/DEF_ACK_DLY.
- clkreq sampled high at edge k in OFF -> clkack/clken high after edge k+req_dly+2. Counting: UP_WAIT entered at k, ON entered at k+req_dly+1, registered outputs visible after k+req_dly+2. Delay 0 gives clkack 2 cycles after the request.
- clkreq sampled low at edge k in ON -> clkack/clken low after edge k+ack_dly+2.
- Max delay 2^DLY_W-1 with no wrap: the counter never decrements below 0.
- Reset mid-operation (any state): the next edge forces OFF and all outputs 0. clkreq still high after reset starts a new UP_WAIT on the first non-reset edge.
- Slices are fully independent. Simultaneous requests on all slices resolve in parallel with no arbitration.

## Test plan
- Slice 0, defaults, clkreq 0->1 at cycle 10 -> clkack=1 and clken=1 at cycle 16, busy=1 for cycles 11-15. Drop clkreq at 30 -> clkack=0 at 36.
- Write slice 2 req_dly=0, ack_dly=10, then run the handshake -> ack 2 cycles after the request; release 12 cycles after the drop. Slices 0, 1 and 3 keep a 6-cycle latency.
- Write slice 1 req_dly=20 during its UP_WAIT with 3 counts left -> this handshake completes on the old count. The next handshake takes 22 cycles.
- Drop clkreq on slice 3 during UP_WAIT -> proto_err[3]=1 and stays 1. ON is reached, then DN_WAIT, then OFF with the normal ack_dly.
- cfg_force_on[1]=1 with clkreq=0 -> clken[1]=1 one cycle later, clkack[1]=0 and busy[1]=0 throughout.
- Assert rst during DN_WAIT with clkreq high on all slices -> all outputs 0 the next cycle. After rst drops, all acks return after DEF_REQ_DLY+2 cycles. Write with cfg_slice=NUM_SLICES -> no register change.
